shreg_arbiter: RTL and testbench

Round-robin arbiter and write sequencer for one shared WIDTH-bit storage register built from negative-edge, synchronously cleared flip-flops. Four requesters compete for write ownership of the register. The block grants one requester at a time, loads that requester's data into the register while the grant is held, and rotates priority on release. It sits between the requesting units and the shared register, which it owns and drives as `q`.

---
 rtl/shreg_arb_pkg.sv | 15 +
 rtl/shreg_arbiter_rr_pick.sv | 29 ++
 rtl/shreg_arbiter.sv | 120 ++++++++++++
 tb/tb_shreg_arbiter.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/shreg_arb_pkg.sv
// Shared types and constants for the shared-register round-robin arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package shreg_arb_pkg;

  localparam int NUM_REQ = 4;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_t;

  typedef logic [1:0] owner_t;

endpackage : shreg_arb_pkg

// File: rtl/shreg_arbiter_rr_pick.sv
// Round-robin winner search: first set request bit starting just after `last`.
// Latency: purely combinational, zero cycles.
// Backpressure: none; `valid` is low when no request bit is set.
module rr_pick
  import shreg_arb_pkg::*;
(
  input  logic [NUM_REQ-1:0] req,
  input  logic [1:0]         last,
  output logic               valid,
  output logic [1:0]         idx
);

  owner_t cand;

  // Walk last+1, last+2, last+3, last (2-bit wrap) and keep the first hit.
  always_comb begin
    valid = 1'b0;
    idx   = 2'd0;
    cand  = 2'd0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      cand = last + i[1:0];
      if (!valid && req[cand]) begin
        valid = 1'b1;
        idx   = cand;
      end
    end
  end

endmodule : rr_pick

// File: rtl/shreg_arbiter.sv
// Four-way round-robin arbiter owning one shared negedge WIDTH-bit register.
// Latency: grant one falling edge after req, first write on the next edge.
// Backpressure: non-owners wait while a grant is held; the owner releases by
// dropping req. Optional hold limit via macro SHREG_ARB_TIMEOUT_EN.
module shreg_arbiter
  import shreg_arb_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int MAX_HOLD = 4
) (
  input  logic                       clock,
  input  logic                       clear,
  input  logic [NUM_REQ-1:0]         req,
  input  logic [NUM_REQ*WIDTH-1:0]   wdata,
  output logic [NUM_REQ-1:0]         gnt,
  output logic [1:0]                 owner,
  output logic                       busy,
  output logic [WIDTH-1:0]           q
);

  state_t               state_q, state_d;
  logic [NUM_REQ-1:0]   gnt_q, gnt_d;
  owner_t               owner_q, owner_d;
  owner_t               last_q, last_d;
  logic [WIDTH-1:0]     data_q, data_d;

  logic                 pick_vld;
  owner_t               pick_idx;

`ifdef SHREG_ARB_TIMEOUT_EN
  localparam int CW = $clog2(MAX_HOLD + 1);
  logic [CW-1:0]        hold_q, hold_d;
`else
  // The hold limit only matters when the timeout build is selected.
  logic unused_max_hold;
  assign unused_max_hold = (MAX_HOLD > 0);
`endif

  rr_pick u_pick (
    .req   (req),
    .last  (last_q),
    .valid (pick_vld),
    .idx   (pick_idx)
  );

  // Next-state logic: arbitrate in IDLE, write or release in GRANT.
  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    owner_d = owner_q;
    last_d  = last_q;
    data_d  = data_q;
`ifdef SHREG_ARB_TIMEOUT_EN
    hold_d  = hold_q;
`endif
    case (state_q)
      ST_IDLE: begin
        // Arbitration edge: grant only, the register is untouched.
        if (pick_vld) begin
          gnt_d   = 4'b0001 << pick_idx;
          owner_d = pick_idx;
          last_d  = pick_idx;
          state_d = ST_GRANT;
`ifdef SHREG_ARB_TIMEOUT_EN
          hold_d  = '0;
`endif
        end
      end
      ST_GRANT: begin
        if (req[owner_q]) begin
          data_d = wdata[owner_q*WIDTH +: WIDTH];
`ifdef SHREG_ARB_TIMEOUT_EN
          hold_d = hold_q + CW'(1);
          // The write that reaches the limit also ends the grant.
          if (hold_q == CW'(MAX_HOLD - 1)) begin
            gnt_d   = '0;
            state_d = ST_IDLE;
          end
`endif
        end else begin
          gnt_d   = '0;
          state_d = ST_IDLE;
        end
      end
      default: begin
        gnt_d   = '0;
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and shared register, all on the falling edge with clear dominant.
  always_ff @(negedge clock) begin
    if (clear) begin
      state_q <= ST_IDLE;
      gnt_q   <= '0;
      owner_q <= 2'd0;
      last_q  <= 2'd3;
      data_q  <= '0;
`ifdef SHREG_ARB_TIMEOUT_EN
      hold_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      data_q  <= data_d;
`ifdef SHREG_ARB_TIMEOUT_EN
      hold_q  <= hold_d;
`endif
    end
  end

  assign gnt   = gnt_q;
  assign owner = owner_q;
  assign busy  = (state_q == ST_GRANT);
  assign q     = data_q;

endmodule : shreg_arbiter

// File: tb/tb_shreg_arbiter.sv
// Directed bench for shreg_arbiter: stimulus pushes expected output snapshots,
// a monitor pops one per falling edge and compares.
// Timeout scenario is exercised when SHREG_ARB_TIMEOUT_EN is defined.
module tb_shreg_arbiter;

  typedef struct packed {
    logic [3:0] gnt;
    logic [1:0] owner;
    logic       busy;
    logic [7:0] q;
  } snap_t;

  logic        clock;
  logic        clear;
  logic [3:0]  req;
  logic [31:0] wdata;
  logic [3:0]  gnt;
  logic [1:0]  owner;
  logic        busy;
  logic [7:0]  q;

  snap_t exp_q[$];
  string name_q[$];
  int    n_vec;
  int    n_bad;

  shreg_arbiter #(.WIDTH(8), .MAX_HOLD(4)) dut (
    .clock (clock),
    .clear (clear),
    .req   (req),
    .wdata (wdata),
    .gnt   (gnt),
    .owner (owner),
    .busy  (busy),
    .q     (q)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // Drive inputs on the rising edge, queue the expected result of the
  // following falling edge, then let that edge happen.
  task automatic step(input logic clr, input logic [3:0] r, input logic [31:0] wd,
                      input logic [3:0] eg, input logic [1:0] eo, input logic eb,
                      input logic [7:0] eq, input string nm);
    snap_t s;
    @(posedge clock);
    clear = clr;
    req   = r;
    wdata = wd;
    s.gnt = eg; s.owner = eo; s.busy = eb; s.q = eq;
    exp_q.push_back(s);
    name_q.push_back(nm);
    @(negedge clock);
  endtask

  // Monitor: after each falling edge settles, compare the oldest expectation.
  initial begin
    snap_t e;
    snap_t a;
    string nm;
    n_vec = 0;
    n_bad = 0;
    forever begin
      @(negedge clock);
      #2;
      if (exp_q.size() > 0) begin
        e  = exp_q.pop_front();
        nm = name_q.pop_front();
        a.gnt = gnt; a.owner = owner; a.busy = busy; a.q = q;
        n_vec++;
        if (a !== e) begin
          n_bad++;
          $display("FAIL %s: got gnt=%b owner=%0d busy=%b q=%h, expected gnt=%b owner=%0d busy=%b q=%h",
                   nm, a.gnt, a.owner, a.busy, a.q, e.gnt, e.owner, e.busy, e.q);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0]  rr_lane [4];
    logic [31:0] wd;
    logic [3:0]  all_but;
    clear = 1'b0;
    req   = 4'b0;
    wdata = 32'h0;
    rr_lane[0] = 8'h10; rr_lane[1] = 8'h21; rr_lane[2] = 8'h32; rr_lane[3] = 8'h43;

    // 1. clear
    step(1, 4'b0000, 32'h0, 4'b0000, 0, 0, 8'h00, "clear");

    // 2. single requester on lane 2
    wd = 32'h00A5_0000;
    step(0, 4'b0100, wd, 4'b0100, 2, 1, 8'h00, "single_grant");
    step(0, 4'b0100, wd, 4'b0100, 2, 1, 8'hA5, "single_write1");
    step(0, 4'b0100, wd, 4'b0100, 2, 1, 8'hA5, "single_write2");
    step(0, 4'b0000, wd, 4'b0000, 2, 0, 8'hA5, "single_release");
    step(0, 4'b0000, wd, 4'b0000, 2, 0, 8'hA5, "single_idle_hold");

    // 3. round robin from a fresh clear: order 0,1,2,3 then 0 again
    step(1, 4'b0000, 32'h0, 4'b0000, 0, 0, 8'h00, "rr_clear");
    wd = 32'h4332_2110;
    for (int k = 0; k < 4; k++) begin
      all_but = 4'b1111 & ~(4'b0001 << k);
      step(0, 4'b1111, wd, 4'b0001 << k, 2'(k), 1,
           (k == 0) ? 8'h00 : rr_lane[k-1], $sformatf("rr_grant%0d", k));
      step(0, 4'b1111, wd, 4'b0001 << k, 2'(k), 1, rr_lane[k], $sformatf("rr_write%0d", k));
      step(0, all_but, wd, 4'b0000, 2'(k), 0, rr_lane[k], $sformatf("rr_release%0d", k));
    end
    step(0, 4'b1111, wd, 4'b0001, 0, 1, 8'h43, "rr_wrap_grant0");
    step(0, 4'b1110, wd, 4'b0000, 0, 0, 8'h43, "rr_wrap_release");

    // 4. no preemption: requester 0 asks while 1 owns the register
    wd = 32'h0000_5566;
    step(0, 4'b0010, wd, 4'b0010, 1, 1, 8'h43, "nopre_grant1");
    step(0, 4'b0011, wd, 4'b0010, 1, 1, 8'h55, "nopre_write_a");
    step(0, 4'b0011, wd, 4'b0010, 1, 1, 8'h55, "nopre_write_b");
    step(0, 4'b0001, wd, 4'b0000, 1, 0, 8'h55, "nopre_release1");
    step(0, 4'b0001, wd, 4'b0001, 0, 1, 8'h55, "nopre_grant0");
    step(0, 4'b0001, wd, 4'b0001, 0, 1, 8'h66, "nopre_write0");
    step(0, 4'b0000, wd, 4'b0000, 0, 0, 8'h66, "nopre_release0");

    // 5. clear during a grant to requester 3
    wd = 32'h7700_0088;
    step(0, 4'b1000, wd, 4'b1000, 3, 1, 8'h66, "clrmid_grant3");
    step(0, 4'b1000, wd, 4'b1000, 3, 1, 8'h77, "clrmid_write3");
    step(1, 4'b1000, wd, 4'b0000, 0, 0, 8'h00, "clrmid_clear");
    step(0, 4'b1001, wd, 4'b0001, 0, 1, 8'h00, "clrmid_regrant0");
    step(0, 4'b0000, wd, 4'b0000, 0, 0, 8'h00, "clrmid_release");

`ifdef SHREG_ARB_TIMEOUT_EN
    // 6. hold limit of 4 writes, then the other requester wins
    step(1, 4'b0000, 32'h0, 4'b0000, 0, 0, 8'h00, "to_clear");
    wd = 32'h0000_B1A0;
    step(0, 4'b0011, wd, 4'b0001, 0, 1, 8'h00, "to_grant0");
    step(0, 4'b0011, wd, 4'b0001, 0, 1, 8'hA0, "to_write1");
    step(0, 4'b0011, wd, 4'b0001, 0, 1, 8'hA0, "to_write2");
    step(0, 4'b0011, wd, 4'b0001, 0, 1, 8'hA0, "to_write3");
    step(0, 4'b0011, wd, 4'b0000, 0, 0, 8'hA0, "to_write4_drop");
    step(0, 4'b0011, wd, 4'b0010, 1, 1, 8'hA0, "to_grant1");
    step(0, 4'b0011, wd, 4'b0010, 1, 1, 8'hB1, "to_write_b1");
    step(0, 4'b0000, wd, 4'b0000, 1, 0, 8'hB1, "to_release1");
`else
    // 6. without the hold limit a grant survives well past 4 writes
    step(1, 4'b0000, 32'h0, 4'b0000, 0, 0, 8'h00, "hold_clear");
    wd = 32'h0000_B1A0;
    step(0, 4'b0011, wd, 4'b0001, 0, 1, 8'h00, "hold_grant0");
    for (int k = 1; k <= 6; k++)
      step(0, 4'b0011, wd, 4'b0001, 0, 1, 8'hA0, $sformatf("hold_write%0d", k));
    step(0, 4'b0010, wd, 4'b0000, 0, 0, 8'hA0, "hold_release0");
    step(0, 4'b0010, wd, 4'b0010, 1, 1, 8'hA0, "hold_grant1");
    step(0, 4'b0000, wd, 4'b0000, 1, 0, 8'hA0, "hold_release1");
`endif

    // Let the monitor drain; leftovers mean it never saw those edges.
    repeat (3) @(negedge clock);
    #3;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: %0d expectations left unchecked, expected 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule : tb_shreg_arbiter
